// File: rtl/int_to_float.sv
// Pipelined signed-integer to float converter: sign/magnitude, leading-one, normalise, output register.
// Optional INT_TO_FLOAT_RNE_EN: round to nearest even instead of truncating the discarded bits.
module int_to_float #(
  parameter int E_bit = 8,
  parameter int F_bit = 23,
  parameter int I_bit = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [I_bit-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [E_bit+F_bit:0]   out_data
);

  localparam int PW   = $clog2(I_bit);
  localparam int W    = I_bit + F_bit + 1;
  localparam int BIAS = (1 << (E_bit - 1)) - 1;

  logic                 stall;
  logic                 s0_valid_q, s0_sign_q, s0_sign_d;
  logic [I_bit-1:0]     s0_mag_q, s0_mag_d;
  logic                 s1_valid_q, s1_sign_q, s1_zero_q, s1_zero_d;
  logic [I_bit-1:0]     s1_mag_q;
  logic [PW-1:0]        s1_pos_q, s1_pos_d;
  logic                 s2_valid_q;
  logic [E_bit+F_bit:0] s2_data_q, s2_data_d;
  logic                 out_valid_q;
  logic [E_bit+F_bit:0] out_data_q;

  logic [I_bit-1:0]     shifted;
  logic [W-1:0]         ext;
  logic [F_bit-1:0]     frac;
  logic [E_bit-1:0]     expo;
  logic                 ext_unused;
`ifdef INT_TO_FLOAT_RNE_EN
  logic                 guard, sticky, round_up, carry;
`endif

  // Every stage holds while the output is blocked, so a single stall term gates the whole pipe.
  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Magnitude of the most negative input still fits unsigned in I_bit bits.
  always_comb begin
    s0_sign_d = in_data[I_bit-1];
    s0_mag_d  = s0_sign_d ? -in_data : in_data;
  end

  // NOTE: every always_comb output gets a default before any conditional assignment, so no latch is inferred.
  always_comb begin
    s1_pos_d = '0;
    for (int i = 0; i < I_bit; i++) begin
      if (s0_mag_q[i]) s1_pos_d = PW'(i);
    end
    s1_zero_d = (s0_mag_q == '0);
  end

  always_comb begin
    shifted = s1_mag_q << (PW'(I_bit - 1) - s1_pos_q);
    ext     = {shifted, {(F_bit + 1){1'b0}}};
    frac    = ext[W-2 -: F_bit];
    expo    = E_bit'(BIAS) + E_bit'(s1_pos_q);
`ifdef INT_TO_FLOAT_RNE_EN
    ext_unused = ext[W-1];
    guard      = ext[W-2-F_bit];
    sticky     = |ext[W-3-F_bit:0];
    round_up   = guard && (sticky || frac[0]);
    {carry, frac} = {1'b0, frac} + (F_bit + 1)'(round_up);
    expo       = expo + E_bit'(carry);
`else
    ext_unused = ^{ext[W-1], ext[W-2-F_bit:0]};
`endif
    s2_data_d = s1_zero_q ? '0 : {s1_sign_q, expo, frac};
  end

  // NOTE: sequential state uses non-blocking assignments only; every pipeline register is small
  // flop storage, so all of them are cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q  <= 1'b0;
      s0_sign_q   <= 1'b0;
      s0_mag_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_pos_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (!stall) begin
      s0_valid_q  <= in_valid;
      s0_sign_q   <= s0_sign_d;
      s0_mag_q    <= s0_mag_d;
      s1_valid_q  <= s0_valid_q;
      s1_sign_q   <= s0_sign_q;
      s1_zero_q   <= s1_zero_d;
      s1_mag_q    <= s0_mag_q;
      s1_pos_q    <= s1_pos_d;
      s2_valid_q  <= s1_valid_q;
      s2_data_q   <= s2_data_d;
      out_valid_q <= s2_valid_q;
      // Bubbles leave the last result visible on out_data.
      if (s2_valid_q) out_data_q <= s2_data_q;
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Scoreboard bench for int_to_float (default parameters); expected floats come from spec constants
// or an independent arithmetic model that follows INT_TO_FLOAT_RNE_EN.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;
  int          vectors = 0;
  int          miscompares = 0;

  int_to_float dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] x);
    longint m, rem, frac;
    int     e;
    logic   s;
`ifdef INT_TO_FLOAT_RNE_EN
    longint low, half;
`endif
    if (x == 32'd0) return 32'd0;
    s = x[31];
    m = s ? (longint'(1) << 32) - longint'(x) : longint'(x);
    e = 31;
    while (((m >> e) & 1) == 0) e--;
    rem = m - (longint'(1) << e);
    if (e <= 23) frac = rem << (23 - e);
    else begin
      frac = rem >> (e - 23);
`ifdef INT_TO_FLOAT_RNE_EN
      low  = rem & ((longint'(1) << (e - 23)) - 1);
      half = longint'(1) << (e - 24);
      if (low > half || (low == half && (frac & 1) != 0)) frac = frac + 1;
      if (frac == (longint'(1) << 23)) begin
        frac = 0;
        e    = e + 1;
      end
`endif
    end
    return {s, 8'(127 + e), 23'(frac)};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got %h with no result pending", out_data);
      end else begin
        mon_exp = sb.pop_front();
        if (out_data !== mon_exp) begin
          miscompares++;
          $display("FAIL result_order: got %h, expected %h", out_data, mon_exp);
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] expv);
    in_valid = 1'b1;
    in_data  = x;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(expv);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout: in_ready stayed %b for %h, expected 1", in_ready, x);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    #2 rst_n = 1'b0;
    #20;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: out_valid=%b out_data=%h in_ready=%b, expected 0/00000000/1",
               out_valid, out_data, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency(input logic [31:0] x, input logic [31:0] expv);
    int k;
    send(x, expv);
    in_valid = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    vectors++;
    if (k != 3) begin
      miscompares++;
      $display("FAIL latency: result after %0d edges, expected 3", k);
    end
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (out_valid !== 1'b0 || out_data !== expv) begin
      miscompares++;
      $display("FAIL bubble_hold: out_valid=%b out_data=%h, expected 0/%h", out_valid, out_data, expv);
    end
  endtask

  task automatic test_values();
    send(32'h0000_0001, 32'h3F80_0000);
    send(32'hFFFF_FFFF, 32'hBF80_0000);
    send(32'h8000_0000, 32'hCF00_0000);
    send(32'h0000_0000, 32'h0000_0000);
`ifdef INT_TO_FLOAT_RNE_EN
    send(32'h7FFF_FFFF, 32'h4F00_0000);
    send(32'h0100_0003, 32'h4B80_0002);
`else
    send(32'h7FFF_FFFF, 32'h4EFF_FFFF);
    send(32'h0100_0003, 32'h4B80_0001);
`endif
    send(32'h0000_0005, 32'h40A0_0000);
    send(32'hFFFF_FFFB, 32'hC0A0_0000);
    for (int i = 0; i < 12; i++) begin
      logic [31:0] r;
      r = $urandom;
      send(r, model(r));
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[8];
    int idx = 0;
    for (int i = 0; i < 8; i++) vals[i] = $urandom;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = 1'b1;
      in_data   = vals[idx];
      @(negedge clk);
      vectors++;
      if (in_ready !== !(c >= 4 && c <= 6)) begin
        miscompares++;
        $display("FAIL stall_ready: cycle %0d in_ready=%b, expected %b", c, in_ready, !(c >= 4 && c <= 6));
      end
      if (in_ready) begin
        sb.push_back(model(vals[idx]));
        idx++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_async_reset();
    int seen = 0;
    for (int i = 0; i < 4; i++) send(32'h0000_1000 + 32'(i), model(32'h0000_1000 + 32'(i)));
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL inflight_valid: out_valid=%b before reset, expected 1", out_valid);
    end
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: out_valid=%b out_data=%h, expected 0/00000000", out_valid, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stale_after_reset: %0d stale results, in_ready=%b, expected 0/1", seen, in_ready);
    end
    test_latency(32'hFFFF_FFFF, 32'hBF80_0000);
  endtask

  initial begin
    test_reset();
    test_latency(32'h0000_0001, 32'h3F80_0000);
    test_values();
    test_back_to_back();
    test_async_reset();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_to_float.md
INT_TO_FLOAT -- requirements
Module: int_to_float

Interface
REQ-001 Parameter E_bit, default 8, exponent field width of output float.
REQ-002 Parameter F_bit, default 23, fraction field width of output float.
REQ-003 Parameter I_bit, default 32, width of two's-complement integer input.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_data holds a sample to convert.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  I_bit  signed two's-complement integer.
REQ-009 out_valid  output  1  out_data holds a converted result.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  E_bit+F_bit+1  float {sign, exponent, fraction}, bias = 2^(E_bit-1)-1, same packing as the team's float adder input.

Function
REQ-012 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-013 Three-stage pipeline, each stage with its own valid bit:
- S0: register sign and unsigned magnitude (I_bit wide; -2^(I_bit-1) gives magnitude 2^(I_bit-1)).
- S1: leading-one position p of magnitude, registered with the magnitude.
- S2: normalise and pack into the output register.
REQ-014 With out_ready held high, the result for an input accepted at edge N is valid at edge N+3, one result per cycle.
REQ-015 stall = out_valid && !out_ready; on stall, all stages and out_data hold; in_ready = !stall (combinational).
REQ-016 Exponent = bias + p; fraction = the F_bit bits directly below the leading one, left-aligned and zero-padded when p < F_bit.
REQ-017 When p > F_bit, discarded low bits are truncated toward zero unless REQ-024 applies.
REQ-018 Input 0 -> out_data all zeros (+0.0); the sign bit is never set for zero.
REQ-019 Sign bit = in_data[I_bit-1] for every nonzero input.
REQ-020 Bubbles (stage valid = 0) propagate without altering data of valid stages; data of invalid stages is don't-care, except out_data, which holds its last value.
REQ-021 No overflow is possible when bias + I_bit <= 2^E_bit - 2; the exponent is never saturated.

Reset
REQ-022 rst_n low clears all stage valid bits, out_valid = 0, out_data = 0, and all pipeline registers to 0, immediately and regardless of clk.
REQ-023 In-flight samples are discarded on reset; after release, in_ready = 1 and the first accepted sample appears 3 cycles later.

Configuration
REQ-024 Macro INT_TO_FLOAT_RNE_EN.
- Defined: S2 rounds to nearest, ties to even, using the guard bit and the sticky OR of the remaining discarded bits.
- On fraction carry-out, the fraction becomes 0 and the exponent increments by 1.
- Not defined: truncation per REQ-017, matching the float adder's truncating behaviour; no rounding logic is synthesised.

Verification
REQ-025 Reset, then in_data=0x00000001, then 0xFFFFFFFF, out_ready=1 -> out_data 0x3F800000, then 0xBF800000, each 3 cycles after acceptance.
REQ-026 in_data=0x80000000 -> 0xCF000000; in_data=0x00000000 -> 0x00000000.
REQ-027 in_data=0x7FFFFFFF -> 0x4EFFFFFF without macro, 0x4F000000 with INT_TO_FLOAT_RNE_EN.
REQ-028 in_data=0x01000003 -> 0x4B800001 without macro, 0x4B800002 with macro (tie, round to even).
REQ-029 Back-to-back stream of 8 values with out_ready low for cycles 4-6 -> in_ready low exactly while out_valid && !out_ready, no loss or duplication, results in order.
REQ-030 rst_n asserted asynchronously with 3 samples in flight -> out_valid and out_data drop to 0 before the next clk edge; no stale result appears after release.
